// File: rtl/instr_mem_arbiter_if.sv
// Bus bundle between the instruction-RAM arbiter, its two requesters
// (core fetch port and external loader/debug port) and the RAM itself.
interface instr_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // core fetch port (read-only)
    logic                  core_req;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic                  core_gnt;
    logic                  core_rvalid;
    logic [DATA_WIDTH-1:0] core_rdata;

    // external loader / debug port (read/write)
    logic                  ext_req;
    logic                  ext_we;
    logic [BE_WIDTH-1:0]   ext_be;
    logic [ADDR_WIDTH-1:0] ext_addr;
    logic [DATA_WIDTH-1:0] ext_wdata;
    logic                  ext_gnt;
    logic                  ext_rvalid;
    logic [DATA_WIDTH-1:0] ext_rdata;

    // single-port RAM side
    logic                  mem_en;
    logic                  mem_we;
    logic [BE_WIDTH-1:0]   mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  core_req, core_addr,
        output core_gnt, core_rvalid, core_rdata,
        input  ext_req, ext_we, ext_be, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // requester / RAM side
    modport master (
        output core_req, core_addr,
        input  core_gnt, core_rvalid, core_rdata,
        output ext_req, ext_we, ext_be, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/instr_mem_arbiter.sv
// Shares the single-port instruction RAM between the core fetch port and
// the external loader port. The external port has fixed priority; a
// starvation counter forces a core grant after MAX_WAIT denied cycles.
// Read data (1-cycle RAM latency) is steered back to the issuing port.
module instr_mem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input logic             clk,
    input logic             rst_n,
    instr_mem_arbiter_if.slave bus
);
    localparam int         BE_WIDTH    = DATA_WIDTH / 8;
    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0]            r_wait_cnt;
    logic                  r_rsp_core;
    logic                  r_rsp_ext;
    logic [DATA_WIDTH-1:0] r_rdata_q;

    logic w_force_core;
    logic w_core_gnt;
    logic w_ext_gnt;

    // Grants are gated by rst_n so nothing reaches the RAM while in reset.
    assign w_force_core = bus.core_req && (r_wait_cnt == LP_MAX_WAIT);
    assign w_ext_gnt    = rst_n && bus.ext_req && !w_force_core;
    assign w_core_gnt   = rst_n && bus.core_req && (!bus.ext_req || w_force_core);

    assign bus.core_gnt = w_core_gnt;
    assign bus.ext_gnt  = w_ext_gnt;

    // RAM drive: winner's request, or all zeros when idle.
    assign bus.mem_en   = w_core_gnt | w_ext_gnt;
    assign bus.mem_we   = w_ext_gnt & bus.ext_we;
    assign bus.mem_addr = w_ext_gnt  ? bus.ext_addr  :
                          w_core_gnt ? bus.core_addr : '0;

    // Per byte lane: the core always reads full words, ext passes its own lanes.
    for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
        assign bus.mem_be[gi] = w_ext_gnt ? bus.ext_be[gi] : w_core_gnt;
        assign bus.mem_wdata[gi*8 +: 8] = w_ext_gnt ? bus.ext_wdata[gi*8 +: 8] : 8'h00;
    end

    // Response pipeline: remember who owns the data returning next cycle,
    // and keep the last returned word so rdata holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_core <= 1'b0;
            r_rsp_ext  <= 1'b0;
            r_rdata_q  <= '0;
        end else begin
            r_rsp_core <= w_core_gnt;
            r_rsp_ext  <= w_ext_gnt;
            if (r_rsp_core || r_rsp_ext) begin
                r_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Starvation counter: counts consecutive cycles the core asked and lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (w_core_gnt || !bus.core_req) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != LP_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign bus.core_rvalid = r_rsp_core;
    assign bus.ext_rvalid  = r_rsp_ext;
    assign bus.core_rdata  = r_rsp_core ? bus.mem_rdata : r_rdata_q;
    assign bus.ext_rdata   = r_rsp_ext  ? bus.mem_rdata : r_rdata_q;
endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter with a behavioural 1-cycle RAM.
// Inputs are driven 1 time unit after the rising edge; grants are checked
// 2 units after the edge, responses 1 unit after the following edge.
module tb_instr_mem_arbiter;
    logic clk;
    logic rst_n;
    logic ram_init;
    int   checks   = 0;
    int   failures = 0;

    instr_mem_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    instr_mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: word i preloads to 0xC0DE0000 + i.
    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hC0DE_0000 + 32'(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) ram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
            end else begin
                bus.mem_rdata <= ram[bus.mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic cr, input logic [9:0] ca, input logic er, input logic ew,
                       input logic [3:0] eb, input logic [9:0] ea, input logic [31:0] ed);
        bus.core_req  = cr;
        bus.core_addr = ca;
        bus.ext_req   = er;
        bus.ext_we    = ew;
        bus.ext_be    = eb;
        bus.ext_addr  = ea;
        bus.ext_wdata = ed;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        ram_init = 1'b1;
        // requests present during reset must not be granted
        drv(1'b1, 10'd3, 1'b1, 1'b1, 4'hF, 10'd4, 32'h1234_5678);
        tick();
        chk("rst_core_gnt", bus.core_gnt, 1'b0);
        chk("rst_ext_gnt", bus.ext_gnt, 1'b0);
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 10'd0);
        chk("rst_core_rvalid", bus.core_rvalid, 1'b0);
        chk("rst_ext_rvalid", bus.ext_rvalid, 1'b0);
        chk("rst_core_rdata", bus.core_rdata, 32'h0);
        ram_init = 1'b0;
        drv(1'b0, 10'd0, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        rst_n = 1'b1;
        tick();

        // 1. core-only streaming, addresses 0..3
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 10'(k), 1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
            #1;
            chk("t1_core_gnt", bus.core_gnt, 1'b1);
            chk("t1_ext_gnt", bus.ext_gnt, 1'b0);
            chk("t1_mem_we", bus.mem_we, 1'b0);
            chk("t1_mem_be", bus.mem_be, 4'hF);
            chk("t1_mem_addr", bus.mem_addr, 32'(k));
            tick();
            chk("t1_core_rvalid", bus.core_rvalid, 1'b1);
            chk("t1_ext_rvalid", bus.ext_rvalid, 1'b0);
            chk("t1_core_rdata", bus.core_rdata, 32'hC0DE_0000 + 32'(k));
        end
        drv(1'b0, 10'd0, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        #1;
        chk("t1_idle_mem_en", bus.mem_en, 1'b0);
        tick();
        chk("t1_idle_rvalid", bus.core_rvalid, 1'b0);
        chk("t1_hold_rdata", bus.core_rdata, 32'hC0DE_0003);

        // 2. ext write then ext read of addr 5, then core read of addr 5
        drv(1'b0, 10'd0, 1'b1, 1'b1, 4'hF, 10'd5, 32'hDEAD_BEEF);
        #1;
        chk("t2_wr_gnt", bus.ext_gnt, 1'b1);
        chk("t2_wr_mem_we", bus.mem_we, 1'b1);
        chk("t2_wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("t2_wr_ack", bus.ext_rvalid, 1'b1);
        drv(1'b0, 10'd0, 1'b1, 1'b0, 4'hF, 10'd5, 32'h0);
        #1;
        chk("t2_rd_gnt", bus.ext_gnt, 1'b1);
        tick();
        chk("t2_rd_rvalid", bus.ext_rvalid, 1'b1);
        chk("t2_rd_rdata", bus.ext_rdata, 32'hDEAD_BEEF);
        drv(1'b1, 10'd5, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        #1;
        chk("t2_core_gnt", bus.core_gnt, 1'b1);
        tick();
        chk("t2_core_rvalid", bus.core_rvalid, 1'b1);
        chk("t2_core_rdata", bus.core_rdata, 32'hDEAD_BEEF);

        // 4. byte enables on addr 2
        drv(1'b0, 10'd0, 1'b1, 1'b1, 4'hF, 10'd2, 32'h1122_3344);
        tick();
        drv(1'b0, 10'd0, 1'b1, 1'b1, 4'b0101, 10'd2, 32'hAABB_CCDD);
        #1;
        chk("t4_mem_be", bus.mem_be, 4'b0101);
        tick();
        drv(1'b0, 10'd0, 1'b1, 1'b0, 4'h0, 10'd2, 32'h0);
        tick();
        chk("t4_rvalid", bus.ext_rvalid, 1'b1);
        chk("t4_rdata", bus.ext_rdata, 32'h11BB_33DD);

        // 3. contention for 10 cycles: core wins on cycles 4 and 9
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, 10'd1, 1'b1, 1'b0, 4'h0, 10'd9, 32'h0);
            #1;
            chk($sformatf("t3_core_gnt_c%0d", i), bus.core_gnt, (i == 4 || i == 9));
            chk($sformatf("t3_ext_gnt_c%0d", i), bus.ext_gnt, !(i == 4 || i == 9));
            tick();
            if (i == 4 || i == 9) begin
                chk($sformatf("t3_core_rdata_c%0d", i), bus.core_rdata, 32'hC0DE_0001);
                chk($sformatf("t3_ext_rvalid_c%0d", i), bus.ext_rvalid, 1'b0);
            end else begin
                chk($sformatf("t3_ext_rdata_c%0d", i), bus.ext_rdata, 32'hC0DE_0009);
                chk($sformatf("t3_core_rvalid_c%0d", i), bus.core_rvalid, 1'b0);
            end
        end

        // 6. alternating owners: ext addr 7, core addr 8
        for (int r = 0; r < 2; r++) begin
            drv(1'b0, 10'd0, 1'b1, 1'b0, 4'h0, 10'd7, 32'h0);
            tick();
            chk("t6_ext_rvalid", bus.ext_rvalid, 1'b1);
            chk("t6_ext_no_core", bus.core_rvalid, 1'b0);
            chk("t6_ext_rdata", bus.ext_rdata, 32'hC0DE_0007);
            drv(1'b1, 10'd8, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
            tick();
            chk("t6_core_rvalid", bus.core_rvalid, 1'b1);
            chk("t6_core_no_ext", bus.ext_rvalid, 1'b0);
            chk("t6_core_rdata", bus.core_rdata, 32'hC0DE_0008);
        end

        // 5. async reset mid-burst, with wait_cnt built up to 2 beforehand
        drv(1'b1, 10'd0, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        tick();
        drv(1'b1, 10'd1, 1'b1, 1'b0, 4'h0, 10'd9, 32'h0);
        tick();
        tick();
        #1;
        chk("t5_pre_ext_gnt", bus.ext_gnt, 1'b1);
        chk("t5_pre_ext_rvalid", bus.ext_rvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ext_gnt", bus.ext_gnt, 1'b0);
        chk("t5_rst_core_gnt", bus.core_gnt, 1'b0);
        chk("t5_rst_mem_en", bus.mem_en, 1'b0);
        chk("t5_rst_ext_rvalid", bus.ext_rvalid, 1'b0);
        chk("t5_rst_ext_rdata", bus.ext_rdata, 32'h0);
        tick();
        drv(1'b0, 10'd0, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("t5_post_core_rvalid", bus.core_rvalid, 1'b0);
        chk("t5_post_ext_rvalid", bus.ext_rvalid, 1'b0);
        // a cleared counter lets ext win 4 cycles before the core is forced
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 10'd1, 1'b1, 1'b0, 4'h0, 10'd9, 32'h0);
            #1;
            chk($sformatf("t5_core_gnt_c%0d", i), bus.core_gnt, (i == 4));
            tick();
        end
        drv(1'b0, 10'd0, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_mem_arbiter.md
Name: instr_mem_arbiter

Overview:
- Shares the single-port instruction RAM between two requesters: the core fetch port (read-only) and the external AXI/loader port (read/write, used for program load and debug).
- Sits in top_CoreMem between if_stage, the AXI slave bridge (axi_instr_req path) and sp_ram_wrap_instr.
- Arbitration: fixed priority to the external port, with a starvation guard that guarantees the core a slot after MAX_WAIT lost cycles.
- Routes 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- ADDR_WIDTH, 10, word address width of instruction RAM
- DATA_WIDTH, 32, data width (byte enables = DATA_WIDTH/8)
- MAX_WAIT, 4, consecutive denied core cycles before core is forced to win; range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_req  in  1  core fetch request
- core_addr  in  ADDR_WIDTH  core word address
- core_gnt  out  1  core request accepted this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_WIDTH  core read data
- ext_req  in  1  external request
- ext_we  in  1  1 = write, 0 = read
- ext_be  in  DATA_WIDTH/8  byte enables for writes
- ext_addr  in  ADDR_WIDTH  external word address
- ext_wdata  in  DATA_WIDTH  external write data
- ext_gnt  out  1  external request accepted this cycle
- ext_rvalid  out  1  external response valid (read data or write ack)
- ext_rdata  out  DATA_WIDTH  external read data
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_be  out  DATA_WIDTH/8  RAM byte enables
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after an enabled read

Behaviour:
- Clocking and reset: single clock domain; async active-low reset on rst_n.
- Grants (combinational, same cycle as request):
  - force_core = core_req && (wait_cnt == MAX_WAIT).
  - ext_gnt = ext_req && !force_core.
  - core_gnt = core_req && (!ext_req || force_core).
  - At most one grant per cycle.
- RAM drive:
  - mem_en = core_gnt | ext_gnt.
  - mem_addr, mem_we, mem_be and mem_wdata come from the winner.
  - Core access: mem_we = 0, mem_be = all ones, mem_wdata = 0.
  - Idle (no grant): mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
- Response pipeline (registered):
  - rsp_core <= core_gnt; rsp_ext <= ext_gnt.
  - core_rvalid = rsp_core, exactly 1 cycle after core_gnt.
  - ext_rvalid = rsp_ext, exactly 1 cycle after ext_gnt; asserted for both reads and writes (write ack).
- Read data:
  - rdata_q captures mem_rdata whenever rsp_core or rsp_ext is high.
  - core_rdata/ext_rdata = mem_rdata while the respective rvalid is high, else rdata_q (holds last returned word).
  - ext_rdata for a write response is don't-care.
- Starvation counter wait_cnt (4 bits):
  - Increments when core_req && !core_gnt; saturates at MAX_WAIT.
  - Clears to 0 on core_gnt or when core_req is low.
- Back-to-back: a grant is possible every cycle; no bubbles; the response pipeline is fully pipelined.
- Simultaneous ext write and core read to the same address: ext wins unless forced; the core reads afterwards and sees new data. No read-during-write forwarding is needed, since accesses are serialized.
- Reset values: wait_cnt = 0, rsp_core = 0, rsp_ext = 0, rdata_q = 0. All outputs 0 while rst_n is low (grants are gated by rst_n).
- Reset mid-operation: in-flight responses are dropped. The rvalid pulse for a grant issued the cycle before reset assertion is not produced.
- Requester rules:
  - Requesters hold req, addr, we, be and wdata stable until gnt.
  - The arbiter never grants a request that was deasserted before gnt.

Test Plan:
1. Core only: core_req held, addresses 0,1,2,3 → core_gnt every cycle; core_rvalid 1 cycle later with RAM words; mem_we = 0 throughout.
2. Ext load: ext writes 0xDEADBEEF to addr 5 with be = 4'hF, then ext reads addr 5 → ext_gnt both cycles, ext_rvalid for each, read returns 0xDEADBEEF. Then a core read of addr 5 returns 0xDEADBEEF.
3. Contention with MAX_WAIT = 4: ext_req and core_req both held 10 cycles → ext granted cycles 0–3, core granted cycle 4, wait_cnt back to 0, ext cycles 5–8, core cycle 9.
4. Byte enables: preload addr 2 = 0x11223344; ext write 0xAABBCCDD with be = 4'b0101 → readback 0x11BB33DD.
5. Async reset mid-burst: assert rst_n low between clock edges during core streaming → all outputs 0 immediately; no rvalid after release until a new grant. wait_cnt = 0.
6. Routing check: alternate ext read addr 7 and core read addr 8 on successive cycles → each rvalid is asserted only on its owner's port, with the correct data; no cross-delivery.
